// File: rtl/imm_pack_pkg.sv
// Shared immediate-format definitions for the instruction immediate packer and
// the matching sign-extension decoder. Format codes: 00 I, 01 S, 10 B, 11 J.
package imm_pack_pkg;

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } imm_fmt_e;

    // Packed field covers instruction bits [31:7]
    localparam int FIELD_W    = 25;
    localparam int FIFO_DEPTH = 2;

    // Scatter the immediate into instruction bits [31:7]. Non-immediate bits
    // come from base; immediate bits beyond the format's reach are dropped.
    function automatic logic [FIELD_W-1:0] pack_field(
        input imm_fmt_e           fmt,
        input logic [31:0]        imm,
        input logic [FIELD_W-1:0] base
    );
        logic [31:0] ins;
        ins = {base, 7'b0};
        unique case (fmt)
            FMT_I: begin
                ins[31:20] = imm[11:0];
            end
            FMT_S: begin
                ins[31:25] = imm[11:5];
                ins[11:7]  = imm[4:0];
            end
            FMT_B: begin
                ins[31]    = imm[12];
                ins[30:25] = imm[10:5];
                ins[11:8]  = imm[4:1];
                ins[7]     = imm[11];
            end
            FMT_J: begin
                ins[31]    = imm[20];
                ins[30:21] = imm[10:1];
                ins[20]    = imm[11];
                ins[19:12] = imm[19:12];
            end
        endcase
        return ins[31:7];
    endfunction

    // High when the immediate does not fit the format or breaks 2-byte alignment.
    function automatic logic imm_range_err(
        input imm_fmt_e    fmt,
        input logic [31:0] imm
    );
        logic err;
        unique case (fmt)
            FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
        endcase
        return err;
    endfunction

    // Sign-extension decoder: recover the byte offset from instruction bits [31:7].
    function automatic logic [31:0] decode_imm(
        input imm_fmt_e           fmt,
        input logic [FIELD_W-1:0] field
    );
        logic [31:0] ins;
        logic [31:0] imm;
        ins = {field, 7'b0};
        unique case (fmt)
            FMT_I: imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_J: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Immediate packer: scatters a signed byte offset into the I/S/B/J instruction
// layout, flags out-of-range or misaligned offsets, and buffers results in a
// 2-entry FIFO with valid/ready handshakes on both sides.
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_type,
    input  logic [31:0]        in_imm,
    input  logic [24:0]        in_base,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [24:0]        out_field,
    output logic               out_err,
    output logic [CNT_W-1:0]   err_count
);

    // Saturating increment for the error counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    imm_fmt_e             w_fmt;
    logic [FIELD_W-1:0]   w_field;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_pop;
    logic [FIELD_W:0]     w_head;

    logic [FIELD_W:0]     r_mem [FIFO_DEPTH];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_cnt;
    logic [CNT_W-1:0]     r_err_cnt;

    // Combinational packer and range check on the incoming request
    always_comb begin
        w_fmt   = imm_fmt_e'(in_type);
        w_field = pack_field(w_fmt, in_imm, in_base);
        w_err   = imm_range_err(w_fmt, in_imm);
    end

    // Handshakes depend only on registered occupancy
    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // FIFO control and error counter; reset discards any buffered entries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= ~r_wptr;
                if (w_err) begin
                    r_err_cnt <= sat_inc(r_err_cnt);
                end
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the occupancy count
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= {w_err, w_field};
        end
    end

    // Head entry gated to zero while the FIFO is empty
    assign w_head    = r_mem[r_rptr];
    assign out_field = out_valid ? w_head[FIELD_W-1:0] : '0;
    assign out_err   = out_valid && w_head[FIELD_W];
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: table of single-request vectors, then hand sequences for
// backpressure, reset with buffered entries, and a randomized decode round trip.
module tb_imm_pack;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_type;
    logic [31:0]      in_imm;
    logic [24:0]      in_base;
    logic             out_valid;
    logic             out_ready;
    logic [24:0]      out_field;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    int n_chk  = 0;
    int n_fail = 0;

    imm_pack #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] imm;
        logic [24:0] base;
        logic [31:0] exp_ins;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One request through an empty FIFO with out_ready high
    task automatic send_one(input string name, input logic [1:0] t, input logic [31:0] imm,
                            input logic [24:0] base, input logic [31:0] exp_ins, input logic exp_err);
        @(negedge clk);
        in_type  = t;
        in_imm   = imm;
        in_base  = base;
        in_valid = 1'b1;
        chk({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({name, " out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, " field"}, {out_field, 7'b0}, exp_ins);
        chk({name, " err"}, {31'b0, out_err}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        chk({name, " drained valid"}, {31'b0, out_valid}, 32'd0);
        chk({name, " drained field"}, {7'b0, out_field}, 32'd0);
    endtask

    function automatic logic [31:0] tb_decode(input logic [1:0] t, input logic [24:0] f);
        logic [31:0] ins;
        logic [31:0] v;
        ins = {f, 7'b0};
        case (t)
            2'b00:   v = {{20{ins[31]}}, ins[31:20]};
            2'b01:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'b10:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
        return v;
    endfunction

    function automatic logic tb_range_err(input logic [1:0] t, input logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (t)
            2'b00, 2'b01: return (v < -2048) || (v > 2047);
            2'b10:        return (v < -4096) || (v > 4095) || imm[0];
            default:      return (v < -(1 << 20)) || (v > (1 << 20) - 1) || imm[0];
        endcase
    endfunction

    function automatic logic [31:0] tb_base_mask(input logic [1:0] t);
        case (t)
            2'b00:        return 32'h000F_FF80;
            2'b01, 2'b10: return 32'h01FF_F000;
            default:      return 32'h0000_0F80;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFF_F800, 25'h0,       32'h8000_0000, 1'b0};
        vecs[1]  = '{2'b00, 32'h0000_07FF, 25'h0,       32'h7FF0_0000, 1'b0};
        vecs[2]  = '{2'b00, 32'h0000_0800, 25'h0,       32'h8000_0000, 1'b1};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 25'h0,       32'hFE00_0F80, 1'b0};
        vecs[4]  = '{2'b01, 32'h0000_0025, 25'h0,       32'h0200_0280, 1'b0};
        vecs[5]  = '{2'b10, 32'h0000_0FFE, 25'h0,       32'h7E00_0F80, 1'b0};
        vecs[6]  = '{2'b10, 32'h0000_1001, 25'h0,       32'h8000_0000, 1'b1};
        vecs[7]  = '{2'b11, 32'h0010_0000, 25'h0,       32'h8000_0000, 1'b1};
        vecs[8]  = '{2'b11, 32'hFFF0_0000, 25'h0,       32'h8000_0000, 1'b0};
        vecs[9]  = '{2'b11, 32'h000F_FFFE, 25'h0,       32'h7FFF_F000, 1'b0};
        vecs[10] = '{2'b10, 32'h0000_0003, 25'h0,       32'h0000_0100, 1'b1};
        vecs[11] = '{2'b00, 32'h0000_0123, 25'h1FF_FFFF, 32'h123F_FF80, 1'b0};
        vecs[12] = '{2'b01, 32'h0000_0000, 25'h1FF_FFFF, 32'h01FF_F000, 1'b0};
        vecs[13] = '{2'b11, 32'h0000_0000, 25'h1FF_FFFF, 32'h0000_0F80, 1'b0};
        vecs[14] = '{2'b11, 32'h0000_0001, 25'h0,       32'h0000_0000, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_type   = 2'b00;
        in_imm    = '0;
        in_base   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_field", {7'b0, out_field}, 32'd0);
        chk("reset out_err", {31'b0, out_err}, 32'd0);
        chk("reset err_count", {16'b0, err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);

        // Table of single requests
        for (int i = 0; i < 15; i++) begin
            send_one($sformatf("vec%0d", i), vecs[i].typ, vecs[i].imm, vecs[i].base,
                     vecs[i].exp_ins, vecs[i].exp_err);
        end
        chk("table err_count", {16'b0, err_count}, 32'd5);

        // B-format pair after a fresh reset: only the second one is an error
        do_reset();
        send_one("B 0xFFE", 2'b10, 32'h0000_0FFE, 25'h0, 32'h7E00_0F80, 1'b0);
        send_one("B 0x1001", 2'b10, 32'h0000_1001, 25'h0, 32'h8000_0000, 1'b1);
        chk("B err_count", {16'b0, err_count}, 32'd1);

        // Backpressure: three back-to-back requests with the consumer stalled
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_type   = 2'b00; in_imm = 32'h0000_0005; in_base = '0;
        @(posedge clk);
        #1;
        chk("bp A visible", {31'b0, out_valid}, 32'd1);
        chk("bp A field", {out_field, 7'b0}, 32'h0050_0000);
        in_type = 2'b01; in_imm = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("bp full in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp A held 1", {out_field, 7'b0}, 32'h0050_0000);
        in_type = 2'b11; in_imm = 32'hFFF0_0000;
        @(posedge clk);
        #1;
        chk("bp C refused", {31'b0, in_ready}, 32'd0);
        chk("bp A held 2", {out_field, 7'b0}, 32'h0050_0000);
        chk("bp A err held", {31'b0, out_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("bp A held 3", {out_field, 7'b0}, 32'h0050_0000);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp B next", {out_field, 7'b0}, 32'hFE00_0F80);
        chk("bp ready after pop", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp C next", {out_field, 7'b0}, 32'h8000_0000);
        chk("bp C valid", {31'b0, out_valid}, 32'd1);
        chk("bp occupancy one", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp drained", {31'b0, out_valid}, 32'd0);

        // Reset with two buffered entries and a request offered during reset
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_type   = 2'b00; in_imm = 32'h0000_0001;
        @(posedge clk);
        #1;
        in_type = 2'b11; in_imm = 32'h0010_0000;
        @(posedge clk);
        #1;
        chk("rst pre full", {31'b0, in_ready}, 32'd0);
        chk("rst pre err_count", {16'b0, err_count}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        in_type = 2'b00; in_imm = 32'h0000_0007;
        @(posedge clk);
        #1;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst out_field", {7'b0, out_field}, 32'd0);
        chk("rst out_err", {31'b0, out_err}, 32'd0);
        chk("rst err_count", {16'b0, err_count}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst request dropped", {31'b0, out_valid}, 32'd0);

        // Randomized round trip through an independent decoder
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  t;
            logic [31:0] r;
            logic [31:0] imm;
            logic [24:0] base;
            logic [31:0] ins;
            logic        e_err;
            t    = 2'($urandom_range(0, 3));
            r    = $urandom;
            base = 25'($urandom);
            case (t)
                2'b00, 2'b01: imm = {{20{r[11]}}, r[11:0]};
                2'b10:        imm = {{19{r[12]}}, r[12:1], 1'b0};
                default:      imm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            if ($urandom_range(0, 3) == 0) imm = $urandom;
            e_err = tb_range_err(t, imm);
            @(negedge clk);
            in_type = t; in_imm = imm; in_base = base; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            ins = {out_field, 7'b0};
            chk($sformatf("rnd%0d err", i), {31'b0, out_err}, {31'b0, e_err});
            chk($sformatf("rnd%0d base", i), ins & tb_base_mask(t), {base, 7'b0} & tb_base_mask(t));
            if (!e_err) begin
                chk($sformatf("rnd%0d decode", i), tb_decode(t, out_field), imm);
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
